// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer for the five-stage MIPS pipeline bring-up path.
// Drives pc_enable/pc_reset, drains on stop and publishes a (PC, cycles) snapshot.
module pipeline_run_controller #(
  parameter int                    ADDR_BITS    = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    CNT_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR   = {DATA_WIDTH{1'b1}},
  parameter int                    DRAIN_CYCLES = 4,
  parameter int                    RESET_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_code,
  output logic                  cmd_ready,
  input  logic [ADDR_BITS-1:0]  pc_addr,
  input  logic [DATA_WIDTH-1:0] pc_instr,
  output logic                  pc_enable,
  output logic                  pc_reset,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  snap_valid,
  output logic [ADDR_BITS-1:0]  snap_pc,
  output logic [CNT_WIDTH-1:0]  snap_cycles,
  output logic [2:0]            dbg_state
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0] CMD_RUN      = 2'd0;
  localparam logic [1:0] CMD_STEP     = 2'd1;
  localparam logic [1:0] CMD_HALT     = 2'd2;
  localparam logic [1:0] CMD_RESET_PC = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_PCRST = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic                   stop_user_q, stop_user_d;
  logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [ADDR_BITS-1:0]   snap_pc_q, snap_pc_d;
  logic [CNT_WIDTH-1:0]   snap_cycles_q, snap_cycles_d;
  logic                   snap_take;
  logic                   halt_hit;
  logic                   cmd_accept;

  assign halt_hit = (pc_instr == HALT_INSTR);

  // Command handshake: a command transfers on any rising edge where
  // cmd_valid && cmd_ready; cmd_ready depends only on state, never on cmd_valid.
  assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
  assign cmd_accept = cmd_valid && cmd_ready;

  // Decoded from state so a halt at fetch stops the PC in the same cycle.
  assign pc_enable = ((state_q == S_RUN) || (state_q == S_STEP)) && !halt_hit;
  assign pc_reset  = (state_q == S_PCRST);
  assign busy      = (state_q == S_RUN) || (state_q == S_STEP) ||
                     (state_q == S_DRAIN) || (state_q == S_PCRST);
  assign done      = (state_q == S_DONE);

  assign cycle_count = cycle_count_q;
  assign snap_valid  = snap_valid_q;
  assign snap_pc     = snap_pc_q;
  assign snap_cycles = snap_cycles_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d     = state_q;
    stop_user_d = stop_user_q;
    drain_cnt_d = drain_cnt_q;
    rst_cnt_d   = rst_cnt_q;
    snap_take   = 1'b0;

    cycle_count_d = cycle_count_q;
    if (pc_enable && (cycle_count_q != {CNT_WIDTH{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (cmd_code)
            CMD_RUN:      state_d = S_RUN;
            CMD_STEP:     state_d = S_STEP;
            CMD_RESET_PC: begin
              state_d   = S_PCRST;
              rst_cnt_d = RW'(RESET_CYCLES - 1);
            end
            default:      state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        // A program stop takes priority over any command in the same cycle.
        if (halt_hit) begin
          state_d     = S_DRAIN;
          stop_user_d = 1'b0;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
        end else if (cmd_accept && (cmd_code == CMD_HALT)) begin
          state_d     = S_DRAIN;
          stop_user_d = 1'b1;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
        end else if (cmd_accept && (cmd_code == CMD_RESET_PC)) begin
          state_d   = S_PCRST;
          rst_cnt_d = RW'(RESET_CYCLES - 1);
        end
      end
      S_STEP: begin
        if (halt_hit) begin
          state_d     = S_DRAIN;
          stop_user_d = 1'b0;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
        end else begin
          state_d   = S_IDLE;
          snap_take = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d   = stop_user_q ? S_IDLE : S_DONE;
          snap_take = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      S_DONE: begin
        if (cmd_accept && (cmd_code == CMD_RESET_PC)) begin
          state_d   = S_PCRST;
          rst_cnt_d = RW'(RESET_CYCLES - 1);
        end
      end
      S_PCRST: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          cycle_count_d = '0;
        end
        if (rst_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q - RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    snap_valid_d  = snap_take;
    snap_pc_d     = snap_take ? pc_addr : snap_pc_q;
    snap_cycles_d = snap_take ? cycle_count_d : snap_cycles_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      stop_user_q   <= 1'b0;
      drain_cnt_q   <= '0;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      snap_valid_q  <= 1'b0;
      snap_pc_q     <= '0;
      snap_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      stop_user_q   <= stop_user_d;
      drain_cnt_q   <= drain_cnt_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      snap_valid_q  <= snap_valid_d;
      snap_pc_q     <= snap_pc_d;
      snap_cycles_q <= snap_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller with a simple fetch-stage model.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_pipeline_run_controller;

  localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_HALT = 2'd2, C_RST = 2'd3;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2,
                         S_DRAIN = 3'd3, S_DONE = 3'd4, S_PCRST = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_code = 2'd0;
  logic        cmd_ready;
  logic [31:0] pc_addr = 32'h0;
  logic [31:0] pc_instr;
  logic [31:0] halt_pc = 32'h10;
  logic        pc_enable, pc_reset, busy, done, snap_valid;
  logic [31:0] cycle_count, snap_pc, snap_cycles;
  logic [2:0]  dbg_state;

  logic        s_cmd_valid = 1'b0;
  logic [1:0]  s_cmd_code = 2'd0;
  logic        s_cmd_ready, s_pc_enable, s_pc_reset, s_busy, s_done, s_snap_valid;
  logic [3:0]  s_cycle_count, s_snap_cycles;
  logic [31:0] s_snap_pc;
  logic [2:0]  s_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Fetch model: PC advances by 4 when enabled, clears on pc_reset.
  always @(posedge clk) begin
    if (pc_reset) pc_addr <= 32'h0;
    else if (pc_enable) pc_addr <= pc_addr + 32'd4;
  end
  assign pc_instr = (pc_addr == halt_pc) ? 32'hFFFF_FFFF : pc_addr;

  pipeline_run_controller u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .pc_addr(pc_addr), .pc_instr(pc_instr),
    .pc_enable(pc_enable), .pc_reset(pc_reset), .busy(busy), .done(done),
    .cycle_count(cycle_count), .snap_valid(snap_valid), .snap_pc(snap_pc),
    .snap_cycles(snap_cycles), .dbg_state(dbg_state)
  );

  pipeline_run_controller #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .cmd_valid(s_cmd_valid), .cmd_code(s_cmd_code),
    .cmd_ready(s_cmd_ready), .pc_addr(32'h0), .pc_instr(32'h0),
    .pc_enable(s_pc_enable), .pc_reset(s_pc_reset), .busy(s_busy), .done(s_done),
    .cycle_count(s_cycle_count), .snap_valid(s_snap_valid), .snap_pc(s_snap_pc),
    .snap_cycles(s_snap_cycles), .dbg_state(s_dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present a command at this negedge; it transfers on the next rising edge.
  task automatic issue(input logic [1:0] code);
    check_eq("cmd_ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_pc_reset();
    issue(C_RST);
    check_eq("pcrst_c1_pc_reset", pc_reset, 1);
    check_eq("pcrst_c1_ready", cmd_ready, 0);
    tick();
    check_eq("pcrst_c2_pc_reset", pc_reset, 1);
    check_eq("pcrst_c2_count", cycle_count, 0);
    tick();
    check_eq("pcrst_end_state", dbg_state, S_IDLE);
    check_eq("pcrst_end_pc_reset", pc_reset, 0);
    check_eq("pcrst_no_snap", snap_valid, 0);
  endtask

  initial begin
    tick(2);
    reset_n = 1'b1;
    tick();
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_pc_enable", pc_enable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_count", cycle_count, 0);
    check_eq("rst_snap_valid", snap_valid, 0);

    // RUN to a HALT at 0x10: four enabled fetches, then drain and DONE.
    halt_pc = 32'h10;
    issue(C_RUN);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_pc_enable", pc_enable, 1);
      tick();
    end
    check_eq("t1_halt_pc", pc_addr, 32'h10);
    check_eq("t1_enable_drop", pc_enable, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t1_drain_state", dbg_state, S_DRAIN);
      check_eq("t1_drain_busy", busy, 1);
      tick();
    end
    check_eq("t1_done", done, 1);
    check_eq("t1_snap_valid", snap_valid, 1);
    check_eq("t1_snap_pc", snap_pc, 32'h10);
    check_eq("t1_snap_cycles", snap_cycles, 4);
    tick();
    check_eq("t1_snap_pulse_end", snap_valid, 0);

    // RUN and STEP in DONE are ignored; RESET_PC clears the counter.
    issue(C_RUN);
    check_eq("t5_run_ignored", dbg_state, S_DONE);
    check_eq("t5_no_enable", pc_enable, 0);
    issue(C_STEP);
    check_eq("t5_step_ignored", dbg_state, S_DONE);
    check_eq("t5_count_held", cycle_count, 4);
    do_pc_reset();

    // RUN, user HALT in the 10th run cycle, then resume.
    halt_pc = 32'hFFFF_FF00;
    issue(C_RUN);
    tick(9);
    check_eq("t3_count_before_halt", cycle_count, 9);
    issue(C_HALT);
    check_eq("t3_drain_state", dbg_state, S_DRAIN);
    tick(4);
    check_eq("t3_idle_state", dbg_state, S_IDLE);
    check_eq("t3_done_low", done, 0);
    check_eq("t3_snap_valid", snap_valid, 1);
    check_eq("t3_snap_cycles", snap_cycles, 10);
    check_eq("t3_snap_pc", snap_pc, 32'h28);
    issue(C_RUN);
    check_eq("t3_resume_count", cycle_count, 10);
    tick();
    check_eq("t3_resume_incr", cycle_count, 11);
    tick();
    issue(C_HALT);
    tick(4);
    check_eq("t3_resume_snap_cycles", snap_cycles, 13);
    check_eq("t3_resume_snap_pc", snap_pc, 32'h34);
    do_pc_reset();

    // Three single steps.
    for (int i = 0; i < 3; i++) begin
      issue(C_STEP);
      check_eq("t2_step_state", dbg_state, S_STEP);
      check_eq("t2_step_enable", pc_enable, 1);
      check_eq("t2_step_ready", cmd_ready, 0);
      tick();
      check_eq("t2_step_idle", dbg_state, S_IDLE);
      check_eq("t2_step_snap_valid", snap_valid, 1);
      check_eq("t2_step_enable_off", pc_enable, 0);
    end
    check_eq("t2_snap_cycles", snap_cycles, 3);
    check_eq("t2_snap_pc", snap_pc, 32'h08);

    // User HALT on the same cycle as the program HALT: program stop wins.
    do_pc_reset();
    halt_pc = 32'h08;
    issue(C_RUN);
    tick(2);
    check_eq("t4_halt_hit_enable", pc_enable, 0);
    issue(C_HALT);
    check_eq("t4_drain_state", dbg_state, S_DRAIN);
    tick(4);
    check_eq("t4_done", done, 1);
    check_eq("t4_snap_cycles", snap_cycles, 2);

    // Asynchronous reset in the middle of a drain.
    do_pc_reset();
    issue(C_RUN);
    tick(3);
    check_eq("t6_in_drain", dbg_state, S_DRAIN);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_async_pc_enable", pc_enable, 0);
    check_eq("t6_async_pc_reset", pc_reset, 0);
    check_eq("t6_async_busy", busy, 0);
    check_eq("t6_async_done", done, 0);
    check_eq("t6_async_snap_valid", snap_valid, 0);
    check_eq("t6_async_state", dbg_state, S_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_eq("t6_after_state", dbg_state, S_IDLE);
    check_eq("t6_after_count", cycle_count, 0);
    check_eq("t6_after_snap_valid", snap_valid, 0);

    // 4-bit counter saturates at 15.
    s_cmd_valid = 1'b1;
    s_cmd_code  = C_RUN;
    tick();
    s_cmd_valid = 1'b0;
    tick(14);
    check_eq("t7_count_14", s_cycle_count, 14);
    tick();
    check_eq("t7_count_15", s_cycle_count, 15);
    tick(5);
    check_eq("t7_count_sat", s_cycle_count, 15);
    check_eq("t7_still_running", s_pc_enable, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
- Sequences the five-stage MIPS pipeline for the debug/bring-up path.
- Accepts run, step, halt and reset-PC commands over a valid/ready handshake, and drives the pipeline's pc_enable and pc_reset.
- Detects the HALT instruction at the fetch output, drains in-flight instructions and then reports completion.
- Counts executed fetch cycles and publishes a snapshot (PC, cycle count) whenever execution stops.

Parameters:
- ADDR_BITS, 32, width of the PC address.
- DATA_WIDTH, 32, width of the instruction word.
- CNT_WIDTH, 32, width of the cycle counter.
- HALT_INSTR, 32'hFFFFFFFF, instruction encoding that terminates a program.
- DRAIN_CYCLES, 4, cycles that pc_enable is held low after a stop, so that ID/EX/MEM/WB retire.
- RESET_CYCLES, 2, cycles that pc_reset is held high for a reset-PC command.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_code  in  2  command: 0 RUN, 1 STEP, 2 HALT, 3 RESET_PC.
- cmd_ready  out  1  command accepted on a cycle with cmd_valid&&cmd_ready.
- pc_addr  in  ADDR_BITS  current PC from fetch.
- pc_instr  in  DATA_WIDTH  instruction at the fetch output.
- pc_enable  out  1  PC advance enable to fetch.
- pc_reset  out  1  PC reset to fetch, active-high.
- busy  out  1  high in RUN, STEP, DRAIN and PCRST.
- done  out  1  high in DONE.
- cycle_count  out  CNT_WIDTH  fetch cycles with pc_enable high since the last RESET_PC.
- snap_valid  out  1  one-cycle pulse when a snapshot is updated.
- snap_pc  out  ADDR_BITS  pc_addr latched at the stop.
- snap_cycles  out  CNT_WIDTH  cycle_count latched at the stop.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state goes to IDLE; all registered outputs go to 0.
  - pc_enable and pc_reset read 0 immediately, because they are decoded from state.
  - Any in-progress run, step, drain or reset-PC is abandoned; no snapshot is produced.
- States: IDLE, RUN, STEP, DRAIN, DONE, PCRST.
- halt_hit = (pc_instr == HALT_INSTR).
- Combinational outputs:
  - pc_enable = (RUN || STEP) && !halt_hit. The PC therefore never advances past HALT.
  - pc_reset = (state == PCRST).
- cmd_ready = 1 in IDLE, RUN and DONE; 0 in STEP, DRAIN and PCRST.
- IDLE:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - RESET_PC goes to PCRST.
  - HALT is accepted and ignored.
- RUN:
  - halt_hit goes to DRAIN with stop_kind=PROGRAM. halt_hit wins over a HALT or RESET_PC command accepted the same cycle; that command is dropped.
  - Otherwise, HALT goes to DRAIN with stop_kind=USER.
  - Otherwise, RESET_PC goes to PCRST with no drain.
  - RUN and STEP are accepted and ignored.
- STEP: lasts exactly one cycle.
  - halt_hit goes to DRAIN with stop_kind=PROGRAM.
  - Otherwise returns to IDLE with a snapshot.
- DRAIN:
  - Down-counter loaded with DRAIN_CYCLES-1 on entry; exactly DRAIN_CYCLES cycles in the state.
  - On expiry: PROGRAM goes to DONE, USER goes to IDLE; a snapshot is taken either way.
- DONE:
  - done=1.
  - Only RESET_PC (goes to PCRST) leaves DONE; RUN, STEP and HALT are accepted and ignored.
- PCRST:
  - Exactly RESET_CYCLES cycles, then IDLE.
  - cycle_count is cleared on the first PCRST cycle.
  - No snapshot is taken.
- Counter:
  - cycle_count increments on each clock edge where pc_enable=1.
  - It saturates at all-ones and does not wrap.
- Snapshot:
  - On the edge that enters IDLE from STEP/DRAIN, or enters DONE, snap_pc <= pc_addr and snap_cycles <= cycle_count (including that cycle's increment).
  - snap_valid is high for the following single cycle.
  - snap_pc and snap_cycles hold until the next snapshot.
- Latency:
  - A command accepted at edge N takes effect in state from cycle N+1.
  - The first pc_enable pulse of a RUN occurs in cycle N+1.

Test Plan:
- Reset, then RUN with HALT_INSTR at PC 0x10 (instructions at PC 0x00..0x0C are non-HALT):
  - pc_enable is high for 4 cycles, then drops while pc_addr=0x10.
  - After 4 DRAIN cycles: done=1, snap_pc=0x10, snap_cycles=4, one snap_valid pulse.
- Three STEP commands from IDLE (instructions at PC 0x00..0x08 are non-HALT):
  - Each gives exactly one pc_enable cycle and then a snap_valid pulse.
  - Final snap_cycles=3; cmd_ready=0 during each STEP cycle.
- RUN, then HALT command after 10 cycles:
  - Goes through DRAIN (4 cycles) to IDLE with done=0 and snap_cycles=10.
  - A following RUN resumes counting from 10.
- HALT command in RUN on the same cycle that halt_hit is first high:
  - Ends in DONE (program stop wins) with done=1.
- RESET_PC in DONE:
  - pc_reset high for 2 cycles, cycle_count=0, then IDLE.
  - RUN and STEP issued in DONE beforehand had no effect.
- reset_n asserted mid-DRAIN:
  - pc_enable, pc_reset, busy, done and snap_valid all read 0 immediately.
  - state is IDLE and cycle_count=0 after reset_n is released.
- CNT_WIDTH=4, RUN for 20 cycles:
  - cycle_count holds at 15 and does not wrap.
